// File: rtl/p1v_reset_ctrl_pkg.sv
// Shared definitions for the p1v reset sequencer: FSM state encodings, reset cause codes,
// and the saturating reset counter helper.
package p1v_reset_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEB  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RST_POR = 2'd0,
    RST_EXT = 2'd1,
    RST_SW  = 2'd2,
    RST_BRK = 2'd3
  } cause_e;

  localparam logic [7:0] RST_COUNT_MAX = 8'hFF;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == RST_COUNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/p1v_reset_ctrl_if.sv
// Reset source inputs and reset/status outputs of the p1v reset sequencer.
// master drives the pads and soft request; slave is the sequencer itself.
interface p1v_reset_ctrl_if;
  logic       ext_resn;
  logic       rx_pin;
  logic       sw_rst_req;
  logic       p1v_resn;
  logic       rst_busy;
  logic [1:0] rst_cause;
  logic [7:0] rst_count;

  modport master (
    output ext_resn, rx_pin, sw_rst_req,
    input  p1v_resn, rst_busy, rst_cause, rst_count
  );

  modport slave (
    input  ext_resn, rx_pin, sw_rst_req,
    output p1v_resn, rst_busy, rst_cause, rst_count
  );
endinterface

// File: rtl/p1v_reset_ctrl_sync.sv
// STAGES-deep synchroniser for an asynchronous pad; resets to 1 (pad idle level).
// Latency: STAGES clock edges.
module p1v_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/p1v_reset_ctrl.sv
// p1v core reset sequencer: debounced pad reset, soft reset, min hold time, cause/count report.
// Optional serial BREAK reset source enabled by defining BREAK_RESET_EN.
module p1v_reset_ctrl
  import p1v_reset_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 160000,
  parameter int unsigned HOLD_CYC     = 160000,
  parameter int unsigned BREAK_CYC    = 16000000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic            clock_160,
  input  logic            reset,
  p1v_reset_ctrl_if.slave rst_if
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);

  logic ext_s;
  logic rx_s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cause_e           cause_q, cause_d;
  logic [7:0]       count_q, count_d;
  logic             p1v_resn_q, p1v_resn_d;
  logic             rst_busy_q, rst_busy_d;

  logic   hold_src;
  logic   brk_hit;
  logic   enter_hold;
  cause_e hold_cause;

  p1v_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
    .clk_i (clock_160),
    .rst_i (reset),
    .d_i   (rst_if.ext_resn),
    .q_o   (ext_s)
  );

  p1v_sync #(.STAGES(SYNC_STAGES)) u_sync_rx (
    .clk_i (clock_160),
    .rst_i (reset),
    .d_i   (rst_if.rx_pin),
    .q_o   (rx_s)
  );

`ifdef BREAK_RESET_EN
  localparam logic [CNT_W-1:0] BRK_LAST = CNT_W'(BREAK_CYC - 1);

  logic [CNT_W-1:0] brk_cnt_q, brk_cnt_d;
  logic             brk_active;

  // Only counts while the core is running; HOLD waits for rx to go idle instead.
  assign brk_active = (state_q == ST_RUN) || (state_q == ST_DEB);
  assign brk_hit    = brk_active && !rx_s && (brk_cnt_q == BRK_LAST);
  assign brk_cnt_d  = (brk_active && !rx_s && !brk_hit) ? brk_cnt_q + CNT_W'(1) : '0;
  assign hold_src   = !ext_s || rst_if.sw_rst_req || !rx_s;

  always_ff @(posedge clock_160 or posedge reset) begin
    if (reset) begin
      brk_cnt_q <= '0;
    end else begin
      brk_cnt_q <= brk_cnt_d;
    end
  end
`else
  logic rx_unused;

  assign rx_unused = rx_s;
  assign brk_hit   = 1'b0;
  assign hold_src  = !ext_s || rst_if.sw_rst_req;
`endif

  always_ff @(posedge clock_160 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      cnt_q      <= '0;
      cause_q    <= RST_POR;
      count_q    <= '0;
      p1v_resn_q <= 1'b0;
      rst_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      count_q    <= count_d;
      p1v_resn_q <= p1v_resn_d;
      rst_busy_q <= rst_busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    count_d    = count_q;
    enter_hold = 1'b0;
    hold_cause = RST_SW;
    unique case (state_q)
      ST_HOLD: begin
        // Any active source restarts the hold window; cause is left as latched.
        if (hold_src) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (rst_if.sw_rst_req) begin
          enter_hold = 1'b1;
          hold_cause = RST_SW;
        end else if (!ext_s) begin
          state_d = ST_DEB;
          cnt_d   = CNT_W'(1);
        end else if (brk_hit) begin
          enter_hold = 1'b1;
          hold_cause = RST_BRK;
        end
      end
      ST_DEB: begin
        if (rst_if.sw_rst_req) begin
          enter_hold = 1'b1;
          hold_cause = RST_SW;
        end else if (ext_s) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (brk_hit) begin
            enter_hold = 1'b1;
            hold_cause = RST_BRK;
          end
        end else if (cnt_q == DEB_LAST) begin
          enter_hold = 1'b1;
          hold_cause = RST_EXT;
        end else if (brk_hit) begin
          enter_hold = 1'b1;
          hold_cause = RST_BRK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
    endcase
    if (enter_hold) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      cause_d = hold_cause;
      count_d = sat_inc8(count_q);
    end
  end

  always_comb begin
    p1v_resn_d = (state_d != ST_HOLD);
    rst_busy_d = (state_d == ST_HOLD);
  end

  assign rst_if.p1v_resn  = p1v_resn_q;
  assign rst_if.rst_busy  = rst_busy_q;
  assign rst_if.rst_cause = cause_q;
  assign rst_if.rst_count = count_q;

endmodule

// File: tb/tb_p1v_reset_ctrl.sv
// Directed bench for p1v_reset_ctrl with short counters (DEB=4, HOLD=8, BREAK=16, 2 sync stages).
module tb_p1v_reset_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  p1v_reset_ctrl_if rif ();

  p1v_reset_ctrl #(
    .SYNC_STAGES  (2),
    .DEBOUNCE_CYC (4),
    .HOLD_CYC     (8),
    .BREAK_CYC    (16),
    .CNT_W        (24)
  ) dut (
    .clock_160 (clk),
    .reset     (rst),
    .rst_if    (rif)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rif.ext_resn = 1'b1;
    rif.rx_pin = 1'b1;
    rif.sw_rst_req = 1'b0;
    tick(3);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL reset_resn got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", rif.rst_busy); end
    checks++; if (rif.rst_cause !== 2'd0) begin errors++; $display("FAIL reset_cause got %0d want 0", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", rif.rst_count); end
    @(negedge clk);
    rst = 1'b0;
    tick(7);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL por_hold7 got %b want 0", rif.p1v_resn); end
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL por_hold8 got %b want 1", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b0) begin errors++; $display("FAIL por_busy got %b want 0", rif.rst_busy); end
    checks++; if (rif.rst_cause !== 2'd0) begin errors++; $display("FAIL por_cause got %0d want 0", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd0) begin errors++; $display("FAIL por_count got %0d want 0", rif.rst_count); end
  endtask

  task automatic test_glitch();
    rif.ext_resn = 1'b0;
    tick(3);
    rif.ext_resn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL glitch_resn cyc %0d got %b want 1", i, rif.p1v_resn); end
    end
    checks++; if (rif.rst_count !== 8'd0) begin errors++; $display("FAIL glitch_count got %0d want 0", rif.rst_count); end
  endtask

  task automatic test_ext_reset();
    rif.ext_resn = 1'b0;
    tick(5);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL ext_deb3 got %b want 1", rif.p1v_resn); end
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL ext_deb4 got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b1) begin errors++; $display("FAIL ext_busy got %b want 1", rif.rst_busy); end
    checks++; if (rif.rst_cause !== 2'd1) begin errors++; $display("FAIL ext_cause got %0d want 1", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd1) begin errors++; $display("FAIL ext_count got %0d want 1", rif.rst_count); end
    tick(14);
    rif.ext_resn = 1'b1;
    tick(9);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL ext_hold7 got %b want 0", rif.p1v_resn); end
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL ext_hold8 got %b want 1", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b0) begin errors++; $display("FAIL ext_busy_rel got %b want 0", rif.rst_busy); end
  endtask

  task automatic test_sw_reset();
    rif.ext_resn = 1'b0;
    tick(2);
    rif.sw_rst_req = 1'b1;
    tick(1);
    rif.sw_rst_req = 1'b0;
    rif.ext_resn = 1'b1;
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL sw_resn got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_cause !== 2'd2) begin errors++; $display("FAIL sw_cause got %0d want 2", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd2) begin errors++; $display("FAIL sw_count got %0d want 2", rif.rst_count); end
    tick(4);
    rif.sw_rst_req = 1'b1;
    tick(1);
    rif.sw_rst_req = 1'b0;
    tick(7);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL sw_restart7 got %b want 0", rif.p1v_resn); end
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL sw_restart8 got %b want 1", rif.p1v_resn); end
    checks++; if (rif.rst_cause !== 2'd2) begin errors++; $display("FAIL sw_cause_kept got %0d want 2", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd2) begin errors++; $display("FAIL sw_count_kept got %0d want 2", rif.rst_count); end
  endtask

  task automatic test_break();
    int n;
    rif.rx_pin = 1'b0;
    tick(16);
    rif.rx_pin = 1'b1;
`ifdef BREAK_RESET_EN
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL brk_15 got %b want 1", rif.p1v_resn); end
    tick(1);
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL brk_16 got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_cause !== 2'd3) begin errors++; $display("FAIL brk_cause got %0d want 3", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd3) begin errors++; $display("FAIL brk_count got %0d want 3", rif.rst_count); end
    n = 0;
    while (rif.p1v_resn !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL brk_release timeout got %b want 1", rif.p1v_resn); end
`else
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (rif.p1v_resn !== 1'b1) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL nobrk_resn low cycles got %0d want 0", n); end
    checks++; if (rif.rst_count !== 8'd2) begin errors++; $display("FAIL nobrk_count got %0d want 2", rif.rst_count); end
`endif
  endtask

  task automatic test_async_reset();
    int n;
    rif.ext_resn = 1'b0;
    tick(3);
    checks++; if (rif.p1v_resn !== 1'b1) begin errors++; $display("FAIL deb_pre got %b want 1", rif.p1v_resn); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL adeb_resn got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b1) begin errors++; $display("FAIL adeb_busy got %b want 1", rif.rst_busy); end
    checks++; if (rif.rst_cause !== 2'd0) begin errors++; $display("FAIL adeb_cause got %0d want 0", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd0) begin errors++; $display("FAIL adeb_count got %0d want 0", rif.rst_count); end
    rif.ext_resn = 1'b1;
    tick(2);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (rif.p1v_resn !== 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    checks++; if (n !== 8) begin errors++; $display("FAIL apor_hold edges got %0d want 8", n); end
    rif.sw_rst_req = 1'b1;
    tick(1);
    rif.sw_rst_req = 1'b0;
    checks++; if (rif.rst_count !== 8'd1) begin errors++; $display("FAIL ahold_pre_count got %0d want 1", rif.rst_count); end
    tick(3);
    #2 rst = 1'b1;
    #1;
    checks++; if (rif.p1v_resn !== 1'b0) begin errors++; $display("FAIL ahold_resn got %b want 0", rif.p1v_resn); end
    checks++; if (rif.rst_busy !== 1'b1) begin errors++; $display("FAIL ahold_busy got %b want 1", rif.rst_busy); end
    checks++; if (rif.rst_cause !== 2'd0) begin errors++; $display("FAIL ahold_cause got %0d want 0", rif.rst_cause); end
    checks++; if (rif.rst_count !== 8'd0) begin errors++; $display("FAIL ahold_count got %0d want 0", rif.rst_count); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    for (int i = 0; i < 300; i++) begin
      n = 0;
      while (rif.p1v_resn !== 1'b1 && n < 30) begin
        tick(1);
        n++;
      end
      if (rif.p1v_resn !== 1'b1) begin
        checks++; errors++;
        $display("FAIL sat_wait iter %0d got %b want 1", i, rif.p1v_resn);
      end
      rif.sw_rst_req = 1'b1;
      tick(1);
      rif.sw_rst_req = 1'b0;
      if (i == 0) begin
        checks++; if (rif.rst_count !== 8'd1) begin errors++; $display("FAIL sat_first got %0d want 1", rif.rst_count); end
      end
      if (i == 253) begin
        checks++; if (rif.rst_count !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d want 254", rif.rst_count); end
      end
    end
    checks++; if (rif.rst_count !== 8'd255) begin errors++; $display("FAIL sat_final got %0d want 255", rif.rst_count); end
    checks++; if (rif.rst_cause !== 2'd2) begin errors++; $display("FAIL sat_cause got %0d want 2", rif.rst_cause); end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_ext_reset();
    test_sw_reset();
    test_break();
    test_async_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
